// File: rtl/msp430_reset_pkg.sv
// rtl/msp430_reset_pkg.sv - shared types and constants for the MSP430 reset generator
//
// Purpose: state encoding and reset-cause bit positions shared by the reset
// generator and anything that decodes its cause register.
// Ports: none (package).

package msp430_reset_pkg;

  // Sequencer states: drive reset, wait for downstream release, quiescent.
  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    IDLE    = 2'd2
  } rst_state_t;

  // Bit positions inside the sticky cause register {dbg, sw, wdt}.
  localparam int unsigned CAUSE_WDT = 0;
  localparam int unsigned CAUSE_SW  = 1;
  localparam int unsigned CAUSE_DBG = 2;
  localparam int unsigned CAUSE_W   = 3;

endpackage

// File: rtl/msp430_sync_cell.sv
// rtl/msp430_sync_cell.sv - two-flop synchronizer for a single-bit level
//
// Purpose: brings the downstream reset acknowledge level into the clk domain
// before any logic looks at it.
// Ports:
//   clk     - destination clock
//   reset_n - asynchronous active-low reset, clears both stages to 0
//   d_i     - asynchronous input level
//   q_o     - synchronized level, two clk edges of latency

module msp430_sync_cell (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/msp430_reset_gen.sv
// rtl/msp430_reset_gen.sv - reset request merger and assert/release sequencer
//
// Purpose: merges watchdog, software and debug reset requests into one
// registered reset level for the downstream per-domain synchronizers, holds it
// for a minimum time, waits for the downstream domains to acknowledge both
// assertion and release (with a bounded wait), and records the reset cause.
// Parameters:
//   HOLD_CYCLES - minimum number of cycles rst_a_o stays high (>= 1)
//   ACK_TIMEOUT - cycle budget per acknowledge phase (> HOLD_CYCLES)
// Ports:
//   clk           - single clock
//   reset_n       - asynchronous active-low reset
//   wdt_rst_i     - watchdog reset request, one-cycle pulse
//   sw_rst_i      - software reset request, one-cycle pulse
//   dbg_rst_i     - debug reset request, level; holds reset while high
//   rst_ack_i     - downstream synchronized reset level, asynchronous to clk
//   cause_clr_i   - one-cycle pulse clearing cause_o and timeout_err_o
//   rst_a_o       - registered reset request to downstream synchronizers
//   busy_o        - high whenever the sequencer is not idle
//   cause_o       - sticky cause bits {dbg, sw, wdt}; 000 means power-on
//   timeout_err_o - sticky acknowledge-timeout flag

module msp430_reset_gen
  import msp430_reset_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wdt_rst_i,
  input  logic               sw_rst_i,
  input  logic               dbg_rst_i,
  input  logic               rst_ack_i,
  input  logic               cause_clr_i,
  output logic               rst_a_o,
  output logic               busy_o,
  output logic [CAUSE_W-1:0] cause_o,
  output logic               timeout_err_o
);

  // Both counters share one width; the hold load is always smaller than the
  // timeout load, so it fits.
  localparam int unsigned   CW        = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] TMO_LOAD  = CW'(ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  rst_state_t         state_q, state_d;
  logic [CW-1:0]      hold_q, hold_d, hold_dec;
  logic [CW-1:0]      tmo_q, tmo_d, tmo_dec;
  logic               pend_q, pend_d;
  logic               rst_a_q;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               err_q, err_d;
  logic [CAUSE_W-1:0] req_vec;
  logic               req;
  logic               ack_s;
  logic               err_set;
  logic               tmo_count;
  logic               tmo_hit;

  msp430_sync_cell u_ack_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (rst_ack_i),
    .q_o     (ack_s)
  );

  assign req_vec[CAUSE_WDT] = wdt_rst_i;
  assign req_vec[CAUSE_SW]  = sw_rst_i;
  assign req_vec[CAUSE_DBG] = dbg_rst_i;
  assign req                = |req_vec;

  // Saturating decrements: neither counter may wrap below zero.
  assign hold_dec = (hold_q == '0) ? '0 : hold_q - CNT_ONE;
  assign tmo_dec  = (tmo_q == '0) ? '0 : tmo_q - CNT_ONE;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    tmo_d     = tmo_q;
    pend_d    = pend_q;
    err_set   = 1'b0;
    tmo_count = 1'b0;
    tmo_hit   = 1'b0;

    unique case (state_q)
      ASSERT: begin
        hold_d = hold_dec;
        // The ack wait is frozen while debug holds reset: debug may keep the
        // system in reset for any length of time without flagging an error.
        tmo_count = !ack_s && !dbg_rst_i;
        if (tmo_count) begin
          tmo_d   = tmo_dec;
          // Once the budget is used up the ack is treated as seen, so a dead
          // downstream domain cannot deadlock the sequencer.
          tmo_hit = (tmo_dec == '0);
        end
        err_set = tmo_hit;
        // Exit is judged on the decremented hold value so the high time is
        // exactly HOLD_CYCLES cycles.
        if ((hold_dec == '0) && (ack_s || tmo_hit) && !dbg_rst_i) begin
          state_d = RELEASE;
          tmo_d   = TMO_LOAD;
        end
      end

      RELEASE: begin
        // A request here must not be lost: remember it and re-enter reset
        // once the release handshake has completed.
        if (req) begin
          pend_d = 1'b1;
        end
        if (!ack_s) begin
          state_d = IDLE;
        end else begin
          tmo_d = tmo_dec;
          if (tmo_dec == '0) begin
            err_set = 1'b1;
            state_d = IDLE;
          end
        end
      end

      IDLE: begin
        if (req || pend_q) begin
          state_d = ASSERT;
          hold_d  = HOLD_LOAD;
          tmo_d   = TMO_LOAD;
          pend_d  = 1'b0;
        end
      end

      default: begin
        state_d = ASSERT;
      end
    endcase

    // Set wins over clear in the same cycle.
    cause_d = (cause_clr_i ? '0 : cause_q) | req_vec;
    err_d   = (cause_clr_i ? 1'b0 : err_q) | err_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ASSERT;
      hold_q  <= HOLD_LOAD;
      tmo_q   <= TMO_LOAD;
      pend_q  <= 1'b0;
      rst_a_q <= 1'b1;
      cause_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
      pend_q  <= pend_d;
      // Registered from the next state so the output changes on the same
      // edge as the state and is glitch-free towards the async reset inputs.
      rst_a_q <= (state_d == ASSERT);
      cause_q <= cause_d;
      err_q   <= err_d;
    end
  end

  assign rst_a_o       = rst_a_q;
  assign busy_o        = (state_q != IDLE);
  assign cause_o       = cause_q;
  assign timeout_err_o = err_q;

endmodule
